axi4lite_random_slave: RTL and testbench
========================================

// Module: axi4lite_random_slave
// PURPOSE
//  AXI4-Lite responder with a small internal memory, used to soak-test AXI4-Lite masters.
//  Pseudo-randomly stalls AWREADY/WREADY/ARREADY and delays BVALID/RVALID under probability controls.
//  Sits at the far end of an interconnect under test, opposite a traffic generator.
//  One outstanding write and one outstanding read at a time. IDs are echoed for AXI4 interoperability.
// PARAMETERS
//  PROB_W      8   width of probability controls and random compare values (<=9)
//  ADDR_W      16  AxADDR width
//  DATA_BYTEW  4   data bus width in bytes
//  ID_W        4   AxID/xID width
//  MEM_AW      4   log2(memory depth in words); word index = AxADDR[log2(DATA_BYTEW) +: MEM_AW]
// PORTS
//  i_clk          in   1             clock, all logic on posedge
//  i_rst_n        in   1             synchronous reset, active-low
//  i_axi_AWID     in   ID_W          write address ID
//  i_axi_AWADDR   in   ADDR_W        write address
//  i_axi_AWPROT   in   3             ignored
//  i_axi_AWVALID  in   1             write address valid
//  o_axi_AWREADY  out  1             write address ready
//  i_axi_WDATA    in   DATA_BYTEW*8  write data
//  i_axi_WSTRB    in   DATA_BYTEW    byte strobes
//  i_axi_WVALID   in   1             write data valid
//  o_axi_WREADY   out  1             write data ready
//  o_axi_BID      out  ID_W          = captured AWID
//  o_axi_BRESP    out  2             write response
//  o_axi_BVALID   out  1             write response valid
//  i_axi_BREADY   in   1             write response ready
//  i_axi_ARID     in   ID_W          read address ID
//  i_axi_ARADDR   in   ADDR_W        read address
//  i_axi_ARPROT   in   3             ignored
//  i_axi_ARVALID  in   1             read address valid
//  o_axi_ARREADY  out  1             read address ready
//  o_axi_RID      out  ID_W          = captured ARID
//  o_axi_RDATA    out  DATA_BYTEW*8  read data
//  o_axi_RRESP    out  2             read response
//  o_axi_RVALID   out  1             read data valid
//  i_axi_RREADY   in   1             read data ready
//  i_pr_aw_stall / i_pr_w_stall / i_pr_ar_stall / i_pr_b_delay / i_pr_r_delay
//                 in   PROB_W each   stall/delay probability, '0 = never
// BEHAVIOUR
//  - PRNG: prngXoroshiro128p, seeded {1414213562, 2718281828} on every reset deassertion (resetDetect).
//    Stall/delay compare fields are disjoint PROB_W slices of the 64b result.
//    Each do_x = (i_pr_x > rnd_x), evaluated independently per cycle.
//  - Reset (i_rst_n=0 at posedge): all holding flags clear; all memory words = 0.
//    Outputs AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=0, BID=RID=0, RDATA=0.
//    Reset mid-transaction drops all in-flight transactions without response.
//  - AW/W holding regs, each a 1-entry buffer with flag aw_full/w_full:
//    AWREADY = !aw_full && !do_aw_stall && rst_n; WREADY likewise. Captured on VALID&&READY.
//  - Write commit: when aw_full && w_full && !BVALID && !do_b_delay:
//    memory bytes updated per WSTRB; BVALID=1, BID=AWID; aw_full, w_full clear.
//    Min latency: last of AW/W handshakes at cycle N -> BVALID at N+1.
//  - B: BVALID, BID and BRESP are held stable until BREADY; BVALID clears on handshake.
//  - AR holding reg: ARREADY = !ar_full && !do_ar_stall && rst_n.
//  - Read commit: when ar_full && (!RVALID || RREADY) && !do_r_delay:
//    RDATA = mem[idx]; RID = ARID; RVALID=1; ar_full clears.
//    Min latency: AR handshake at N -> RVALID at N+1.
//  - R: RVALID and payload are held stable until RREADY.
//  - Same-cycle read and write commit to the same word: RDATA returns the pre-write value.
//  - Address bits above word index alias (wrap) into memory; sub-word bits are ignored.
//  - READY outputs do not depend combinationally on VALID inputs.
//  - RESP = 2'b00 (OKAY) unless the error feature is enabled.
// CONFIGURATION
//  AXI4LITE_RANDOM_SLAVE_ERR_EN defined:
//    - Adds input i_pr_err (PROB_W).
//    - At each commit, do_err=(i_pr_err > rnd_err) sets BRESP/RRESP=2'b10 (SLVERR).
//    - An errored write leaves memory unchanged; an errored read returns RDATA=0.
//  Undefined: no port; RESP always 2'b00.
// TESTING
//  1 All pr=0, AW 0x0004 ID 3 + W 0xDEADBEEF strb 0xF same cycle, BREADY=1
//    -> AWREADY=WREADY=1; BVALID next cycle, BID=3, BRESP=0.
//  2 Then AR 0x0004 ID 5 -> RVALID 1 cycle after handshake, RDATA=0xDEADBEEF, RID=5.
//  3 Write 0x11223344 strb 0x5 to 0x0008 after reset, read back -> RDATA=0x00220044.
//    Read 0x0048 (MEM_AW=4, alias) -> same data.
//  4 BREADY=0 for 10 cycles after BVALID -> BVALID, BID, BRESP stable; new AW/W accepted into holding only.
//    No second BVALID until the first B handshake.
//  5 All pr='1, random VALIDs, 10k cycles -> protocol checker clean; every handshake answered once with matching ID.
//    Identical trace after re-reset.
//  6 Assert reset with B and R pending -> next cycle all VALID/READY=0; read of 0x0004 -> RDATA=0.

Source files
------------

// File: rtl/axi4lite_random_slave_if.sv
// AXI4-Lite bus bundle for the random-stall responder.
// master drives AW/W/AR and BREADY/RREADY; slave drives READY, B and R.
interface axi4lite_random_slave_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_BYTEW = 4,
  parameter int ID_W       = 4
);
  logic [ID_W-1:0]         AWID;
  logic [ADDR_W-1:0]       AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_BYTEW*8-1:0] WDATA;
  logic [DATA_BYTEW-1:0]   WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_W-1:0]         BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_W-1:0]         ARID;
  logic [ADDR_W-1:0]       ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_W-1:0]         RID;
  logic [DATA_BYTEW*8-1:0] RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4lite_random_slave.sv
// AXI4-Lite soak responder: small memory, xoroshiro128+ driven stalls/delays.
// Ports: i_clk, i_rst_n (sync, low), axi (slave modport), i_pr_* probabilities.
// Optional macro AXI4LITE_RANDOM_SLAVE_ERR_EN adds i_pr_err and SLVERR injection.
module axi4lite_random_slave #(
  parameter int PROB_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_BYTEW = 4,
  parameter int ID_W       = 4,
  parameter int MEM_AW     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  axi4lite_random_slave_if.slave axi,
  input  logic [PROB_W-1:0] i_pr_aw_stall,
  input  logic [PROB_W-1:0] i_pr_w_stall,
  input  logic [PROB_W-1:0] i_pr_ar_stall,
  input  logic [PROB_W-1:0] i_pr_b_delay,
  input  logic [PROB_W-1:0] i_pr_r_delay
`ifdef AXI4LITE_RANDOM_SLAVE_ERR_EN
  ,
  input  logic [PROB_W-1:0] i_pr_err
`endif
);

  localparam int DW    = DATA_BYTEW * 8;
  localparam int DEPTH = 1 << MEM_AW;
  localparam int BO    = (DATA_BYTEW > 1) ? $clog2(DATA_BYTEW) : 0;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [63:0] SEED0  = 64'd1414213562;
  localparam logic [63:0] SEED1  = 64'd2718281828;

  // xoroshiro128+ (a=24, b=16, c=37)
  logic [63:0] s0_q, s0_d;
  logic [63:0] s1_q, s1_d;
  logic [63:0] rnd;
  logic [63:0] mix;

  always_comb begin
    rnd  = s0_q + s1_q;
    mix  = s0_q ^ s1_q;
    s0_d = {s0_q[39:0], s0_q[63:40]} ^ mix ^ (mix << 16);
    s1_d = {mix[26:0], mix[63:27]};
  end

  // Each control compares against its own disjoint slice of rnd
  logic do_aw, do_w, do_ar, do_b, do_r, do_err;

  assign do_aw = i_pr_aw_stall > rnd[0*PROB_W +: PROB_W];
  assign do_w  = i_pr_w_stall  > rnd[1*PROB_W +: PROB_W];
  assign do_ar = i_pr_ar_stall > rnd[2*PROB_W +: PROB_W];
  assign do_b  = i_pr_b_delay  > rnd[3*PROB_W +: PROB_W];
  assign do_r  = i_pr_r_delay  > rnd[4*PROB_W +: PROB_W];

  logic unused_bits;

`ifdef AXI4LITE_RANDOM_SLAVE_ERR_EN
  assign do_err = i_pr_err > rnd[5*PROB_W +: PROB_W];
  assign unused_bits = ^{rnd[63:6*PROB_W], axi.AWPROT, axi.ARPROT,
                         axi.AWADDR, axi.ARADDR};
`else
  assign do_err = 1'b0;
  assign unused_bits = ^{rnd[63:5*PROB_W], axi.AWPROT, axi.ARPROT,
                         axi.AWADDR, axi.ARADDR};
`endif

  // Holding registers
  logic              aw_full_q, aw_full_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [MEM_AW-1:0] awidx_q, awidx_d;
  logic              w_full_q, w_full_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DATA_BYTEW-1:0] wstrb_q, wstrb_d;
  logic              ar_full_q, ar_full_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [MEM_AW-1:0] aridx_q, aridx_d;

  // Response registers
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // READY uses only state and PRNG, never VALID
  logic awready, wready, arready;

  assign awready = !aw_full_q && !do_aw && i_rst_n;
  assign wready  = !w_full_q  && !do_w  && i_rst_n;
  assign arready = !ar_full_q && !do_ar && i_rst_n;

  assign axi.AWREADY = awready;
  assign axi.WREADY  = wready;
  assign axi.ARREADY = arready;
  assign axi.BVALID  = bvalid_q;
  assign axi.BID     = bid_q;
  assign axi.BRESP   = bresp_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RID     = rid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_go, rd_go;

  assign aw_hs = axi.AWVALID && awready;
  assign w_hs  = axi.WVALID  && wready;
  assign ar_hs = axi.ARVALID && arready;
  assign b_hs  = bvalid_q && axi.BREADY;
  assign r_hs  = rvalid_q && axi.RREADY;

  // Write waits for B to fully drain; read may refill on the R handshake
  assign wr_go = aw_full_q && w_full_q && !bvalid_q && !do_b;
  assign rd_go = ar_full_q && (!rvalid_q || axi.RREADY) && !do_r;

  always_comb begin
    aw_full_d = aw_full_q;
    awid_d    = awid_q;
    awidx_d   = awidx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ar_full_d = ar_full_q;
    arid_d    = arid_q;
    aridx_d   = aridx_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    mem_d     = mem_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awid_d    = axi.AWID;
      awidx_d   = axi.AWADDR[BO +: MEM_AW];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = axi.WDATA;
      wstrb_d  = axi.WSTRB;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      arid_d    = axi.ARID;
      aridx_d   = axi.ARADDR[BO +: MEM_AW];
    end

    if (b_hs) bvalid_d = 1'b0;
    if (wr_go) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = awid_q;
      bresp_d   = do_err ? SLVERR : OKAY;
      if (!do_err) begin
        for (int b = 0; b < DATA_BYTEW; b++) begin
          if (wstrb_q[b])
            mem_d[awidx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end

    if (r_hs) rvalid_d = 1'b0;
    // Reads sample mem_q, so a same-cycle write lands after this read
    if (rd_go) begin
      ar_full_d = 1'b0;
      rvalid_d  = 1'b1;
      rid_d     = arid_q;
      rresp_d   = do_err ? SLVERR : OKAY;
      rdata_d   = do_err ? '0 : mem_q[aridx_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s0_q      <= SEED0;
      s1_q      <= SEED1;
      aw_full_q <= 1'b0;
      awid_q    <= '0;
      awidx_q   <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ar_full_q <= 1'b0;
      arid_q    <= '0;
      aridx_q   <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      aw_full_q <= aw_full_d;
      awid_q    <= awid_d;
      awidx_q   <= awidx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ar_full_q <= ar_full_d;
      arid_q    <= arid_d;
      aridx_q   <= aridx_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_random_slave.sv
// Directed bench for axi4lite_random_slave plus a stall soak with ID scoreboard.
// Ports: none; instantiates the bus interface and the DUT.
module tb_axi4lite_random_slave;
  localparam int PW = 8;
  localparam int AW = 16;
  localparam int DB = 4;
  localparam int IW = 4;
  localparam int MA = 4;
  localparam int DW = DB * 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [PW-1:0] pr_aw, pr_w, pr_ar, pr_b, pr_r;
`ifdef AXI4LITE_RANDOM_SLAVE_ERR_EN
  logic [PW-1:0] pr_err;
`endif

  always #5 clk = ~clk;

  axi4lite_random_slave_if #(
    .ADDR_W(AW), .DATA_BYTEW(DB), .ID_W(IW)
  ) bus ();

  axi4lite_random_slave #(
    .PROB_W(PW), .ADDR_W(AW), .DATA_BYTEW(DB),
    .ID_W(IW), .MEM_AW(MA)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .axi           (bus),
    .i_pr_aw_stall (pr_aw),
    .i_pr_w_stall  (pr_w),
    .i_pr_ar_stall (pr_ar),
    .i_pr_b_delay  (pr_b),
    .i_pr_r_delay  (pr_r)
`ifdef AXI4LITE_RANDOM_SLAVE_ERR_EN
    ,
    .i_pr_err      (pr_err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor: handshake flags, ID scoreboard, B/R stability
  logic [IW-1:0] awq[$];
  logic [IW-1:0] arq[$];
  int n_aw = 0, n_b = 0, n_ar = 0, n_r = 0;
  bit aw_hs, w_hs, ar_hs;
  bit b_hold = 0, r_hold = 0;
  logic [IW+2:0] b_snap;
  logic [IW+DW+2:0] r_snap;

  always @(posedge clk) begin
    aw_hs = bus.AWVALID && bus.AWREADY;
    w_hs  = bus.WVALID && bus.WREADY;
    ar_hs = bus.ARVALID && bus.ARREADY;
    if (!rst_n) begin
      awq.delete();
      arq.delete();
      b_hold = 0;
      r_hold = 0;
    end else begin
      if (b_hold)
        chk("b_stable", 64'({bus.BVALID, bus.BID, bus.BRESP}),
            64'(b_snap));
      if (r_hold)
        chk("r_stable",
            64'({bus.RVALID, bus.RID, bus.RDATA, bus.RRESP}),
            64'(r_snap));
      if (aw_hs) begin
        awq.push_back(bus.AWID);
        n_aw++;
      end
      if (ar_hs) begin
        arq.push_back(bus.ARID);
        n_ar++;
      end
      if (bus.BVALID && bus.BREADY) begin
        n_b++;
        chk("b_orphan", 64'(awq.size() > 0), 64'(1));
        if (awq.size() > 0)
          chk("bid_match", 64'(bus.BID), 64'(awq.pop_front()));
      end
      if (bus.RVALID && bus.RREADY) begin
        n_r++;
        chk("r_orphan", 64'(arq.size() > 0), 64'(1));
        if (arq.size() > 0)
          chk("rid_match", 64'(bus.RID), 64'(arq.pop_front()));
      end
      b_hold = bus.BVALID && !bus.BREADY;
      b_snap = {bus.BVALID, bus.BID, bus.BRESP};
      r_hold = bus.RVALID && !bus.RREADY;
      r_snap = {bus.RVALID, bus.RID, bus.RDATA, bus.RRESP};
    end
  end

  task automatic set_pr(input logic [PW-1:0] p);
    pr_aw = p;
    pr_w  = p;
    pr_ar = p;
    pr_b  = p;
    pr_r  = p;
  endtask

  task automatic idle_bus();
    bus.AWVALID = 0;
    bus.WVALID  = 0;
    bus.ARVALID = 0;
    bus.AWID    = '0;
    bus.AWADDR  = '0;
    bus.AWPROT  = '0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.ARID    = '0;
    bus.ARADDR  = '0;
    bus.ARPROT  = '0;
    bus.BREADY  = 1;
    bus.RREADY  = 1;
  endtask

  // Ends on the negedge where rst_n is released
  task automatic rst_seq();
    @(negedge clk);
    rst_n = 0;
    idle_bus();
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  // Returns number of edges taken until both AW and W handshook
  task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] id,
                    input logic [DW-1:0] d, input logic [DB-1:0] s,
                    output int n);
    bit aok, wok;
    aok = 0;
    wok = 0;
    n = 0;
    bus.AWADDR  = a;
    bus.AWID    = id;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.AWVALID = 1;
    bus.WVALID  = 1;
    for (int k = 0; k < 64 && !(aok && wok); k++) begin
      @(posedge clk);
      n++;
      if (bus.AWVALID && bus.AWREADY) aok = 1;
      if (bus.WVALID && bus.WREADY) wok = 1;
      @(negedge clk);
      if (aok) bus.AWVALID = 0;
      if (wok) bus.WVALID = 0;
    end
    chk("wr_hs", 64'(aok && wok), 64'(1));
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [IW-1:0] id);
    bit ok;
    ok = 0;
    bus.ARADDR  = a;
    bus.ARID    = id;
    bus.ARVALID = 1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(posedge clk);
      if (bus.ARVALID && bus.ARREADY) ok = 1;
      @(negedge clk);
      if (ok) bus.ARVALID = 0;
    end
    chk("rd_hs", 64'(ok), 64'(1));
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!bus.BVALID && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (!bus.RVALID && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic trace(output logic [31:0] sig, output int cnt);
    sig = 0;
    cnt = 0;
    rst_seq();
    repeat (64) begin
      @(negedge clk);
      sig = sig * 31 + 32'({bus.AWREADY, bus.WREADY, bus.ARREADY});
      cnt += int'(bus.AWREADY);
    end
  endtask

  initial begin
    int n, lat, a0, b0, cnt1, cnt2;
    logic [31:0] sig1, sig2;
    bit done;

    rst_n = 0;
    set_pr('0);
`ifdef AXI4LITE_RANDOM_SLAVE_ERR_EN
    pr_err = '0;
`endif
    idle_bus();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY,
                        bus.BVALID, bus.RVALID}), 64'(0));
    chk("rst_pay", 64'({bus.BID, bus.BRESP, bus.RID, bus.RRESP}),
        64'(0));
    chk("rst_rdata", 64'(bus.RDATA), 64'(0));

    // 1: same-cycle AW+W, B one cycle after
    rst_seq();
    #1;
    chk("t1_ready", 64'({bus.AWREADY, bus.WREADY}), 64'(2'b11));
    wr(16'h0004, 4'd3, 32'hDEADBEEF, 4'hF, n);
    chk("t1_hs_edges", 64'(n), 64'(1));
    chk("t1_b_early", 64'(bus.BVALID), 64'(0));
    wait_b(lat);
    chk("t1_b_lat", 64'(lat), 64'(1));
    chk("t1_bid", 64'(bus.BID), 64'(3));
    chk("t1_bresp", 64'(bus.BRESP), 64'(0));
    @(negedge clk);
    chk("t1_b_clr", 64'(bus.BVALID), 64'(0));

    // 2: read back
    rd(16'h0004, 4'd5);
    chk("t2_r_early", 64'(bus.RVALID), 64'(0));
    wait_r(lat);
    chk("t2_r_lat", 64'(lat), 64'(1));
    chk("t2_rdata", 64'(bus.RDATA), 64'(32'hDEADBEEF));
    chk("t2_rid", 64'(bus.RID), 64'(5));
    chk("t2_rresp", 64'(bus.RRESP), 64'(0));
    @(negedge clk);
    chk("t2_r_clr", 64'(bus.RVALID), 64'(0));

    // 3: partial strobes and aliasing
    rst_seq();
    wr(16'h0008, 4'd1, 32'h11223344, 4'h5, n);
    wait_b(lat);
    @(negedge clk);
    rd(16'h0008, 4'd2);
    wait_r(lat);
    chk("t3_strb", 64'(bus.RDATA), 64'(32'h00220044));
    @(negedge clk);
    rd(16'h0048, 4'd3);
    wait_r(lat);
    chk("t3_alias", 64'(bus.RDATA), 64'(32'h00220044));
    chk("t3_rid", 64'(bus.RID), 64'(3));
    @(negedge clk);

    // 4: B back-pressure, second write parks in holding
    rst_seq();
    bus.BREADY = 0;
    wr(16'h000C, 4'd7, 32'hA5A5A5A5, 4'hF, n);
    wait_b(lat);
    chk("t4_b_lat", 64'(lat), 64'(1));
    wr(16'h0010, 4'd9, 32'h12345678, 4'hF, n);
    repeat (8) @(negedge clk);
    chk("t4_b_hold", 64'({bus.BVALID, bus.BID, bus.BRESP}),
        64'({1'b1, 4'd7, 2'b00}));
    chk("t4_full", 64'({bus.AWREADY, bus.WREADY}), 64'(0));
    bus.BREADY = 1;
    @(negedge clk);
    chk("t4_b_gap", 64'(bus.BVALID), 64'(0));
    @(negedge clk);
    chk("t4_b2", 64'({bus.BVALID, bus.BID}), 64'({1'b1, 4'd9}));
    chk("t4_free", 64'({bus.AWREADY, bus.WREADY}), 64'(2'b11));
    @(negedge clk);
    rd(16'h000C, 4'd1);
    wait_r(lat);
    chk("t4_rd1", 64'(bus.RDATA), 64'(32'hA5A5A5A5));
    @(negedge clk);
    rd(16'h0010, 4'd2);
    wait_r(lat);
    chk("t4_rd2", 64'(bus.RDATA), 64'(32'h12345678));
    @(negedge clk);

    // 6: reset with B and R pending
    rst_seq();
    bus.BREADY = 0;
    bus.RREADY = 0;
    wr(16'h0004, 4'd2, 32'hCAFEF00D, 4'hF, n);
    wait_b(lat);
    rd(16'h0004, 4'd6);
    wait_r(lat);
    chk("t6_pre", 64'({bus.BVALID, bus.RVALID, bus.RDATA}),
        64'({2'b11, 32'hCAFEF00D}));
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY,
                       bus.BVALID, bus.RVALID}), 64'(0));
    rst_n = 1;
    bus.BREADY = 1;
    bus.RREADY = 1;
    rd(16'h0004, 4'd1);
    wait_r(lat);
    chk("t6_rdata", 64'({bus.RVALID, bus.RID, bus.RDATA}),
        64'({1'b1, 4'd1, 32'h0}));
    @(negedge clk);

    // 5a: stall pattern repeats after re-reset
    set_pr(8'h80);
    trace(sig1, cnt1);
    trace(sig2, cnt2);
    chk("t5_trace", 64'(sig2), 64'(sig1));
    chk("t5_density", 64'(cnt1 >= 8 && cnt1 <= 56), 64'(1));

    // 5b: random soak under heavy stalls
    set_pr(8'hC0);
    rst_seq();
    a0 = n_aw;
    b0 = n_b;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (aw_hs) bus.AWVALID = 0;
      if (w_hs) bus.WVALID = 0;
      if (ar_hs) bus.ARVALID = 0;
      if (!bus.AWVALID && !bus.WVALID && $urandom_range(3) == 0) begin
        bus.AWID    = IW'($urandom);
        bus.AWADDR  = AW'($urandom);
        bus.WDATA   = $urandom;
        bus.WSTRB   = DB'($urandom);
        bus.AWVALID = 1;
        bus.WVALID  = 1;
      end
      if (!bus.ARVALID && $urandom_range(3) == 0) begin
        bus.ARID    = IW'($urandom);
        bus.ARADDR  = AW'($urandom);
        bus.ARVALID = 1;
      end
      bus.BREADY = 1'($urandom_range(1));
      bus.RREADY = 1'($urandom_range(1));
    end
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (aw_hs) bus.AWVALID = 0;
      if (w_hs) bus.WVALID = 0;
      if (ar_hs) bus.ARVALID = 0;
      bus.BREADY = 1;
      bus.RREADY = 1;
      done = !bus.AWVALID && !bus.WVALID && !bus.ARVALID &&
             awq.size() == 0 && arq.size() == 0 &&
             !bus.BVALID && !bus.RVALID;
    end
    chk("t5_drain", 64'(done), 64'(1));
    chk("t5_b_count", 64'(n_b - b0), 64'(n_aw - a0));
    chk("t5_activity", 64'((n_b - b0) > 20), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
